// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide on magnitudes.
// Fixed latency: done pulses in the 34th cycle after the accept edge; start while busy is ignored.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  muldiv_op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state;
  logic [2:0]  op;
  logic [5:0]  cnt;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic        neg_a;
  logic        neg_b;
  logic [63:0] prod;
  logic [31:0] rem;
  logic [31:0] quo;

  // Operand signedness decoded from the incoming funct3
  logic        sign_a_in;
  logic        sign_b_in;
  logic        neg_a_in;
  logic        neg_b_in;
  logic [31:0] mag_a_in;
  logic [31:0] mag_b_in;

  always_comb begin
    sign_a_in = !(muldiv_op == 3'b011 || muldiv_op == 3'b101 || muldiv_op == 3'b111);
    sign_b_in = (muldiv_op == 3'b000 || muldiv_op == 3'b001 ||
                 muldiv_op == 3'b100 || muldiv_op == 3'b110);
    neg_a_in  = sign_a_in & rs1[31];
    neg_b_in  = sign_b_in & rs2[31];
    mag_a_in  = neg_a_in ? (~rs1 + 32'd1) : rs1;
    mag_b_in  = neg_b_in ? (~rs2 + 32'd1) : rs2;
  end

  // One iteration of each datapath; both advance every CALC cycle, op picks the result
  logic [32:0] mul_sum;
  logic [32:0] div_tmp;
  logic [32:0] div_sub;
  logic        div_ge;

  always_comb begin
    mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mag_a} : 33'd0);
    div_tmp = {rem, quo[31]};
    div_sub = div_tmp - {1'b0, mag_b};
    div_ge  = (div_tmp >= {1'b0, mag_b});
  end

  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] res_sel;

  always_comb begin
    prod_fix = (neg_a ^ neg_b) ? (~prod + 64'd1) : prod;
    quo_fix  = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
    rem_fix  = neg_a ? (~rem + 32'd1) : rem;
    res_sel  = 32'd0;
    case (op)
      3'b000:                 res_sel = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: res_sel = prod_fix[63:32];
      // A zero divisor yields all-ones quotient regardless of dividend sign
      3'b100, 3'b101:         res_sel = (mag_b == 32'd0) ? 32'hFFFF_FFFF : quo_fix;
      default:                res_sel = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= 3'd0;
      cnt    <= 6'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      prod   <= 64'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op    <= muldiv_op;
              mag_a <= mag_a_in;
              mag_b <= mag_b_in;
              neg_a <= neg_a_in;
              neg_b <= neg_b_in;
              cnt   <= 6'd0;
              prod  <= {32'd0, mag_b_in};
              rem   <= 32'd0;
              quo   <= mag_a_in;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
          CALC: begin
            prod <= {mul_sum, prod[31:1]};
            if (div_ge) begin
              rem <= div_sub[31:0];
              quo <= {quo[30:0], 1'b1};
            end else begin
              rem <= div_tmp[31:0];
              quo <= {quo[30:0], 1'b0};
            end
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) state <= FIN;
          end
          FIN: begin
            result <= res_sel;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic, special cases, latency and control.
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011;
  localparam logic [2:0] OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  muldiv_op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int passed = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .muldiv_op(muldiv_op),
    .rs1(rs1), .rs2(rs2), .kill(kill), .busy(busy), .done(done), .result(result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one op, scrambles inputs after accept, returns done-cycle index and result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output bit busy_ok);
    muldiv_op = op; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1 = ~a; rs2 = b ^ 32'h5A5A_5A5A; muldiv_op = ~op;
    lat = -1; res = 32'd0; busy_ok = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k; res = result;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end else if (busy !== 1'b1) busy_ok = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    checks++; if (result !== 32'd0) $display("FAIL reset_result got=%h exp=0", result); else passed++;
  endtask

  task automatic run_table(input string name, input logic [2:0] ops[4],
                           input logic [31:0] as[4], input logic [31:0] bs[4], input logic [31:0] exps[4]);
    int lat; logic [31:0] res; bit bok;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], as[i], bs[i], lat, res, bok);
      checks++;
      if (res !== exps[i]) $display("FAIL %s_%0d_result got=%h exp=%h", name, i, res, exps[i]); else passed++;
      checks++;
      if (lat != 34) $display("FAIL %s_%0d_latency got=%0d exp=34", name, i, lat); else passed++;
      checks++;
      if (!bok) $display("FAIL %s_%0d_busy got=bad exp=busy_during_calc", name, i); else passed++;
      checks++;
      if (done !== 1'b0) $display("FAIL %s_%0d_done_width got=%b exp=0", name, i, done); else passed++;
    end
  endtask

  task automatic test_mul();
    run_table("mul", '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU},
              '{32'd7, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF});
  endtask

  task automatic test_div();
    run_table("div", '{OP_DIV, OP_REM, OP_DIVU, OP_REMU},
              '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100},
              '{32'd2, 32'd2, 32'd7, 32'd7},
              '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2});
  endtask

  task automatic test_special();
    run_table("div0", '{OP_DIVU, OP_REM, OP_DIV, OP_REMU},
              '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'hDEAD_BEEF},
              '{32'd0, 32'd0, 32'd0, 32'd0},
              '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hDEAD_BEEF});
    run_table("ovf", '{OP_DIV, OP_REM, OP_DIVU, OP_REM},
              '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFB},
              '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0},
              '{32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFB});
  endtask

  task automatic test_ignore_start();
    int lat = -1; logic [31:0] res = 32'd0;
    muldiv_op = OP_MUL; rs1 = 32'd1000; rs2 = 32'd1000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 10) begin start = 1'b1; muldiv_op = OP_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'd3; end
      else start = 1'b0;
      if (done === 1'b1) begin lat = k; res = result; break; end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (res !== 32'h000F_4240) $display("FAIL ignore_start_result got=%h exp=000f4240", res); else passed++;
    checks++; if (lat != 34) $display("FAIL ignore_start_latency got=%0d exp=34", lat); else passed++;
  endtask

  task automatic test_kill();
    int lat; logic [31:0] res; bit bok; bit saw_done = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, lat, res, bok);
    muldiv_op = OP_MUL; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 20) kill = 1'b1;
      if (k == 21) begin
        kill = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL kill_busy got=%b exp=0", busy); else passed++;
      end
    end
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
    checks++; if (saw_done) $display("FAIL kill_no_done got=done exp=none"); else passed++;
    checks++; if (result !== 32'd14) $display("FAIL kill_result got=%h exp=0000000e", result); else passed++;
    // kill beats start in the same cycle
    muldiv_op = OP_MUL; rs1 = 32'd2; rs2 = 32'd2; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL kill_start_busy got=%b exp=0", busy); else passed++;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin @(negedge clk); if (done === 1'b1) saw_done = 1'b1; end
    checks++; if (saw_done) $display("FAIL kill_start_no_done got=done exp=none"); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat_a = -1; int lat_b = -1; logic [31:0] res_a = 32'd0; logic [31:0] res_b = 32'd0;
    muldiv_op = OP_MUL; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat_a = k; res_a = result;
        muldiv_op = OP_DIVU; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1;
        break;
      end
    end
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin lat_b = k; res_b = result; break; end
    end
    @(posedge clk); #1;
    checks++; if (res_a !== 32'hFFFF_FFEB) $display("FAIL b2b_first_result got=%h exp=ffffffeb", res_a); else passed++;
    checks++; if (lat_a != 34) $display("FAIL b2b_first_latency got=%0d exp=34", lat_a); else passed++;
    checks++; if (res_b !== 32'd14) $display("FAIL b2b_second_result got=%h exp=0000000e", res_b); else passed++;
    checks++; if (lat_b != 34) $display("FAIL b2b_second_latency got=%0d exp=34", lat_b); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] res; bit bok;
    muldiv_op = OP_DIV; rs1 = 32'hFFFF_FF9C; rs2 = 32'd7; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%b exp=0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL rst_mid_done got=%b exp=0", done); else passed++;
    checks++; if (result !== 32'd0) $display("FAIL rst_mid_result got=%h exp=0", result); else passed++;
    @(negedge clk); rst_n = 1'b1;
    issue(OP_DIVU, 32'd9, 32'd3, lat, res, bok);
    checks++; if (res !== 32'd3) $display("FAIL rst_mid_divu_result got=%h exp=3", res); else passed++;
    checks++; if (lat != 34) $display("FAIL rst_mid_divu_latency got=%0d exp=34", lat); else passed++;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; kill = 1'b0; muldiv_op = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
    #2 rst_n = 1'b0;
    #20;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_mul();
    test_div();
    test_special();
    test_ignore_start();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
